// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller between the PC register, the
// instruction-memory request/grant/response port and the IF/ID boundary.
// At most one memory transaction is outstanding. A misaligned pc is never
// sent to memory; a NOP is substituted and flagged with misalign instead.
//
// Optional build macro: IFETCH_BYPASS_EN
//   defined   - the response cycle forwards mem_rdata straight to decode
//               (2 cycles/instruction with zero-wait memory).
//   undefined - instr/instr_valid come from registers only
//               (3 cycles/instruction minimum).
module ifetch_ctrl #(
    parameter int data = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [data-1:0] pc,
    input  logic            flush,
    output logic            stall,
    output logic            mem_req,
    output logic [data-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [data-1:0] mem_rdata,
    output logic [data-1:0] instr,
    output logic            instr_valid,
    input  logic            id_ready,
    output logic            misalign
);

    // REQ: request pc; WAIT: granted, awaiting data; HOLD: presenting instr;
    // DRAIN: a flushed request is still in flight and its data must be dropped.
    localparam logic [1:0] REQ   = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    // addi x0, x0, 0 -- the canonical NOP, also the reset value of instr.
    localparam logic [data-1:0] NOP = data'(32'h0000_0013);

    logic [1:0]      state_reg,  state_next;
    logic [data-1:0] instr_reg,  instr_next;
    logic            valid_reg,  valid_next;
    logic            mis_reg,    mis_next;

    logic            pc_misaligned;
    logic            grant;
    logic            bypass_fire;
    logic            accept_now;

    assign pc_misaligned = (pc[1:0] != 2'b00);

    // Requests only go out for aligned addresses, and never while reset is held.
    assign mem_req  = (state_reg == REQ) && !reset && !pc_misaligned;
    assign mem_addr = pc;

    // A grant only counts if we were actually requesting.
    assign grant = mem_req && mem_gnt;

`ifdef IFETCH_BYPASS_EN
    // Response cycle in WAIT forwards data directly unless it is being flushed.
    assign bypass_fire = (state_reg == WAIT) && mem_rvalid && !flush;
`else
    assign bypass_fire = 1'b0;
`endif

    // Decode takes the forwarded word in the same cycle, so HOLD is skipped.
    assign accept_now = bypass_fire && id_ready;

    assign instr_valid = valid_reg || bypass_fire;
    assign instr       = bypass_fire ? mem_rdata : instr_reg;
    assign misalign    = mis_reg && !bypass_fire;

    // PC may advance only when decode takes an instruction or a redirect happens.
    assign stall = !(instr_valid && id_ready) && !flush;

    // Next-state and output-register logic; flush outranks id_ready everywhere.
    always_comb begin
        state_next = state_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        mis_next   = mis_reg;
        case (state_reg)
            REQ: begin
                if (flush) begin
                    // Ungranted request simply retargets; a granted one must drain.
                    if (grant) begin
                        state_next = DRAIN;
                    end
                end else if (pc_misaligned) begin
                    instr_next = NOP;
                    mis_next   = 1'b1;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end else if (grant) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (flush) begin
                        // Response arrived together with the redirect: drop it.
                        state_next = REQ;
                    end else begin
                        instr_next = mem_rdata;
                        mis_next   = 1'b0;
                        if (accept_now) begin
                            state_next = REQ;
                        end else begin
                            valid_next = 1'b1;
                            state_next = HOLD;
                        end
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            HOLD: begin
                if (flush || id_ready) begin
                    valid_next = 1'b0;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                // The stale response is consumed and discarded; a flush here
                // changes nothing since nothing is being fetched.
                if (mem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
                valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= REQ;
            instr_reg <= NOP;
            valid_reg <= 1'b0;
            mis_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            mis_reg   <= mis_next;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: randomized bench for ifetch_ctrl. A random-latency memory
// and a PC register drive the DUT; a transaction-level reference model
// (held instruction slot, pending/dropped response flags) predicts every
// output each cycle. Honors IFETCH_BYPASS_EN the same way as the design.
module tb_ifetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        id_ready;
    logic        misalign;

    ifetch_ctrl #(.data(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .id_ready    (id_ready),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus knobs (percentages / limits)
    int          gnt_pct, dly_max, rdy_pct, flush_pct, mis_pct;
    logic        fixed_en;
    logic [31:0] fixed_data;

    // reference model: one instruction slot toward decode, one memory response
    logic        m_held;   // an instruction is sitting at the IF/ID boundary
    logic        m_pend;   // a granted request's response is still owed
    logic        m_drop;   // that owed response belongs to a flushed fetch
    logic [31:0] m_word;   // last instruction word delivered
    logic        m_mis;    // last delivered word was a misalign NOP

    // memory and PC register models
    logic        mem_busy;
    int          mem_dly;
    logic [31:0] pc_pend;
    logic        obs_stall;

`ifdef IFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] new_target();
        logic [31:0] t;
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(99) < mis_pct) t[1:0] = 2'($urandom_range(3, 1));
        return t;
    endfunction

    task automatic set_knobs(input int g, input int d, input int r, input int f, input int m);
        gnt_pct = g; dly_max = d; rdy_pct = r; flush_pct = f; mis_pct = m;
    endtask

    // One clock cycle: drive inputs after negedge, check, advance the models.
    task automatic do_cycle();
        logic        byp, e_valid, e_req, e_stall, e_mis;
        logic [31:0] e_instr;
        @(negedge clk);
        reset      = 1'b0;
        pc         = pc_pend;
        flush      = ($urandom_range(99) < flush_pct);
        id_ready   = ($urandom_range(99) < rdy_pct);
        mem_rvalid = mem_busy && (mem_dly == 0);
        mem_rdata  = fixed_en ? fixed_data : $urandom;
        mem_gnt    = 1'b0;
        #1;
        mem_gnt    = !mem_busy && mem_req && ($urandom_range(99) < gnt_pct);
        #1;

        byp     = BYPASS && m_pend && !m_drop && mem_rvalid && !flush;
        e_valid = m_held || byp;
        e_instr = byp ? mem_rdata : m_word;
        e_mis   = byp ? 1'b0 : m_mis;
        e_req   = !m_held && !m_pend && (pc[1:0] == 2'b00);
        e_stall = !(e_valid && id_ready) && !flush;

        check_eq("mem_req",     32'(mem_req),     32'(e_req));
        check_eq("instr_valid", 32'(instr_valid), 32'(e_valid));
        check_eq("instr",       instr,            e_instr);
        check_eq("misalign",    32'(misalign),    32'(e_mis));
        check_eq("stall",       32'(stall),       32'(e_stall));
        if (e_req) check_eq("mem_addr", mem_addr, pc);
        obs_stall = stall;

        if (e_valid && id_ready && !flush)
            $display("xfer pc=%h instr=%h misalign=%0d", pc, e_instr, e_mis);

        // model advance
        if (m_pend) begin
            if (mem_rvalid) begin
                m_pend = 1'b0;
                if (!m_drop && !flush) begin
                    m_word = mem_rdata;
                    m_mis  = 1'b0;
                    m_held = !(BYPASS && id_ready);
                end
                m_drop = 1'b0;
            end else if (flush) begin
                m_drop = 1'b1;
            end
        end else if (m_held) begin
            if (flush || id_ready) m_held = 1'b0;
        end else begin
            if (flush) begin
                if (e_req && mem_gnt) begin m_pend = 1'b1; m_drop = 1'b1; end
            end else if (pc[1:0] != 2'b00) begin
                m_held = 1'b1; m_word = NOP; m_mis = 1'b1;
            end else if (e_req && mem_gnt) begin
                m_pend = 1'b1; m_drop = 1'b0;
            end
        end

        // memory advance
        if (mem_rvalid) mem_busy = 1'b0;
        else if (mem_busy && mem_dly > 0) mem_dly--;
        if (mem_gnt) begin
            mem_busy = 1'b1;
            mem_dly  = $urandom_range(dly_max, 0);
        end

        // PC register advance (applied at the next negedge)
        if (flush)         pc_pend = new_target();
        else if (!e_stall) pc_pend = pc + 32'd4;
    endtask

    // Assert reset asynchronously between edges and check its immediate effect.
    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; id_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #2;
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_mem_req",     32'(mem_req),     32'd0);
        check_eq("rst_instr",       instr,            NOP);
        check_eq("rst_misalign",    32'(misalign),    32'd0);
        check_eq("rst_stall",       32'(stall),       32'd1);
        m_held = 1'b0; m_pend = 1'b0; m_drop = 1'b0; m_word = NOP; m_mis = 1'b0;
        mem_busy = 1'b0; mem_dly = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int   acc_cyc;
        logic found;
        reset = 1'b1; pc = 32'd0; flush = 1'b0; id_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        fixed_en = 1'b0; fixed_data = 32'd0; pc_pend = 32'd0; obs_stall = 1'b1;
        set_knobs(100, 0, 100, 0, 0);
        reset_dut();

        // zero-wait memory, decode always ready: first acceptance latency
        fixed_en = 1'b1; fixed_data = 32'h0050_0093; pc_pend = 32'd0;
        acc_cyc = 99;
        for (int i = 0; i < 6; i++) begin
            do_cycle();
            if (!obs_stall && acc_cyc == 99) acc_cyc = i;
        end
        check_eq("first_accept_cycle", 32'(acc_cyc), BYPASS ? 32'd1 : 32'd2);
        fixed_en = 1'b0;

        // misaligned pc: NOP substitution, no memory request
        reset_dut();
        pc_pend = 32'h0000_0102;
        for (int i = 0; i < 6; i++) do_cycle();

        // general random traffic with stalls, flushes and misaligned targets
        reset_dut();
        pc_pend = 32'h0000_1000;
        set_knobs(50, 3, 60, 10, 20);
        for (int i = 0; i < 800; i++) do_cycle();

        // slow decode: long HOLD periods
        set_knobs(40, 3, 15, 0, 10);
        for (int i = 0; i < 200; i++) do_cycle();

        // flush-heavy traffic: drains and discarded responses
        set_knobs(70, 3, 50, 40, 10);
        for (int i = 0; i < 300; i++) do_cycle();

        // reset while a response is owed, then resume
        set_knobs(100, 3, 50, 0, 0);
        pc_pend = 32'h0000_2000;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            do_cycle();
            if (m_pend && !m_drop) found = 1'b1;
        end
        check_eq("reach_wait", 32'(found), 32'd1);
        reset_dut();
        set_knobs(60, 2, 70, 5, 5);
        for (int i = 0; i < 100; i++) do_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller: the consumer side of the PC register. Takes the current `pc`, issues a request/grant/response transaction to instruction memory, and holds the returned word for the decode stage. Drives `stall` back to the PC register so the PC advances only when the instruction for the current address has been handed to decode. Sits between the PC register, the instruction-memory port and the IF/ID boundary.

## Interface
- `data`, 32: address and instruction width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  data  current fetch address from the PC register.
- `flush`  in  1  redirect: abandon current fetch; PC loads a new target this cycle.
- `stall`  out  data=1  hold PC (PC loads `pc_next` only when 0).
- `mem_req`  out  1  fetch request valid.
- `mem_addr`  out  data  fetch address; equals `pc` whenever `mem_req`=1.
- `mem_gnt`  in  1  memory accepted request this cycle.
- `mem_rvalid`  in  1  read data valid; never earlier than the cycle after `mem_gnt`.
- `mem_rdata`  in  data  instruction word.
- `instr`  out  data  instruction to decode.
- `instr_valid`  out  1  `instr` valid.
- `id_ready`  in  1  decode accepts `instr` when `instr_valid`=1.
- `misalign`  out  1  current `instr` is a substituted NOP for a misaligned `pc`.

## Operation
- States: REQ, WAIT, HOLD, DRAIN. One outstanding memory transaction maximum.
- REQ: `mem_req`=1, `mem_addr`=`pc`. `mem_gnt` -> WAIT. If `pc[1:0]`≠0: no request issued; capture `instr`=32'h00000013, `misalign`=1, `instr_valid`=1 next cycle, -> HOLD.
- WAIT: `mem_rvalid` -> register `mem_rdata` into `instr`, `misalign`=0, -> HOLD.
- HOLD: `instr_valid`=1; `instr` stable. `id_ready` -> `instr_valid`=0 next cycle, -> REQ.
- `stall` = !( `instr_valid` && `id_ready` ) && !`flush` (combinational).
- Flush (priority over `id_ready`):
  - REQ without `mem_gnt`: stay REQ (request tracks new `pc` next cycle). REQ with `mem_gnt`: -> DRAIN.
  - WAIT with `mem_rvalid`: discard data, -> REQ. WAIT without: -> DRAIN.
  - HOLD: `instr_valid`=0 next cycle, -> REQ.
  - DRAIN: stay DRAIN.
- DRAIN: `mem_req`=0; `mem_rvalid` -> discard, -> REQ. `stall`=1 unless `flush`.
- A discarded response never reaches `instr`/`instr_valid`.

## Timing
- Reset (async, any state): state REQ, `instr`=32'h00000013, `instr_valid`=0, `misalign`=0; `mem_req`=0 while `reset`=1. Outstanding memory response arriving after reset is ignored only if it arrives in REQ (no grant pending) — memory is reset together with this block.
- First `mem_req` in the first cycle after `reset` deasserts.
- Zero-wait memory (`mem_gnt` in REQ cycle, `mem_rvalid` next cycle), `id_ready`=1: grant cycle 0, capture cycle 1, `instr_valid` cycle 2, `stall`=0 cycle 2, PC updates at end of cycle 2 -> 3 cycles/instruction.
- Extra wait cycles on `mem_gnt`/`mem_rvalid`/`id_ready` add 1:1.
- Misaligned `pc`: `instr_valid` one cycle after entering REQ.

## Configuration
- `IFETCH_BYPASS_EN` defined: in WAIT, the `mem_rvalid` cycle drives `instr`=`mem_rdata` and `instr_valid`=1 combinationally; if `id_ready` also 1, `stall`=0 that cycle and -> REQ directly (HOLD skipped); otherwise data registered and -> HOLD. Zero-wait throughput 2 cycles/instruction. `flush` in that cycle still discards and forces `instr_valid`=0.
- Not defined: `instr`/`instr_valid` are registered-only outputs; 3 cycles/instruction minimum.

## Test plan
- Reset release, `pc`=0, zero-wait memory returning 32'h00500093, `id_ready`=1 -> `mem_req` cycle 0, `instr`=32'h00500093 `instr_valid`=1 cycle 2, `stall`=0 only in cycle 2 (cycle 1 with `IFETCH_BYPASS_EN`).
- `mem_gnt` delayed 3 cycles, `mem_rvalid` delayed 2 -> `mem_addr` stable at `pc` throughout, `stall`=1 until delivery, single request issued.
- `id_ready`=0 for 4 cycles in HOLD -> `instr` unchanged, `stall`=1, no new `mem_req` until acceptance.
- `flush` in WAIT without `mem_rvalid`, response 32'hDEADBEEF arrives 2 cycles later -> DRAIN, 32'hDEADBEEF never on `instr`, next `mem_req` for new `pc` cycle after response.
- `pc`=32'h00000102 -> no `mem_req`, `instr`=32'h00000013, `misalign`=1, `instr_valid`=1.
- `reset` asserted mid-WAIT -> immediately `instr_valid`=0, `mem_req`=0, `instr`=32'h00000013; fetch restarts from REQ after release.
